// File: rtl/placement_readout.sv
// placement_readout: scans the placement grid RAM and streams every occupied cell as an (x, y, node) record.
// Optional feature macro CONSISTENCY_CHECK_EN adds a pos_X/pos_Y cross-check per record (out_err, err_count).
module placement_readout #(
    parameter int N       = 6,
    parameter int DATA_W  = 32,
    parameter int GRID_AW = 6,
    parameter int POS_AW  = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     grid_re,
    output logic [GRID_AW-1:0]       grid_addr,
    input  logic signed [DATA_W-1:0] grid_dout,
    output logic                     px_re,
    output logic                     py_re,
    output logic [POS_AW-1:0]        px_addr,
    output logic [POS_AW-1:0]        py_addr,
    input  logic signed [DATA_W-1:0] px_dout,
    input  logic signed [DATA_W-1:0] py_dout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_x,
    output logic signed [DATA_W-1:0] out_y,
    output logic signed [DATA_W-1:0] out_node,
    output logic                     out_err,
    output logic [DATA_W-1:0]        occ_count,
    output logic [DATA_W-1:0]        err_count
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, G_RD, G_WAIT, P_RD, P_WAIT, EMIT, DONE} state_t;

    state_t                     state, state_next;
    logic [CW-1:0]              cell_x, cell_y;
    logic [CW-1:0]              next_x, next_y;
    logic signed [DATA_W-1:0]   node_q;
    logic                       cell_empty;
    logic                       last_cell;

    function automatic logic signed [DATA_W-1:0] coord_ext(input logic [CW-1:0] c);
        return $signed({{(DATA_W-CW){1'b0}}, c});
    endfunction

    assign cell_empty = (grid_dout == '1);
    assign last_cell  = (cell_x == CW'(N-1)) && (cell_y == CW'(N-1));
    assign grid_addr  = GRID_AW'(cell_x) * GRID_AW'(N) + GRID_AW'(cell_y);
    assign out_node   = node_q;

    // Column-major walk: y runs fastest; the last cell wraps back to (0, 0).
    always_comb begin
        next_x = cell_x;
        next_y = cell_y + CW'(1);
        if (cell_y == CW'(N-1)) begin
            next_y = '0;
            next_x = last_cell ? '0 : cell_x + CW'(1);
        end
    end

`ifdef CONSISTENCY_CHECK_EN
    logic pos_mismatch;
    assign pos_mismatch = (px_dout != coord_ext(cell_x)) || (py_dout != coord_ext(cell_y));
    assign px_addr      = node_q[POS_AW-1:0];
    assign py_addr      = node_q[POS_AW-1:0];
`else
    logic unused_pos;
    assign unused_pos = ^{px_dout, py_dout};
    assign px_addr    = '0;
    assign py_addr    = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = G_RD;
            G_RD:   state_next = G_WAIT;
            G_WAIT: begin
                if (cell_empty) begin
                    state_next = last_cell ? DONE : G_RD;
                end else begin
`ifdef CONSISTENCY_CHECK_EN
                    state_next = P_RD;
`else
                    state_next = EMIT;
`endif
                end
            end
            P_RD:   state_next = P_WAIT;
            P_WAIT: state_next = EMIT;
            EMIT:   if (out_ready) state_next = last_cell ? DONE : G_RD;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All strobes and status flags decode the state register only, so out_ready never reaches an output.
    always_comb begin
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        grid_re   = (state == G_RD);
        out_valid = (state == EMIT);
`ifdef CONSISTENCY_CHECK_EN
        px_re     = (state == P_RD);
        py_re     = (state == P_RD);
`else
        px_re     = 1'b0;
        py_re     = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cell_x    <= '0;
            cell_y    <= '0;
            node_q    <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_err   <= 1'b0;
            occ_count <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cell_x    <= '0;
                        cell_y    <= '0;
                        occ_count <= '0;
                        err_count <= '0;
                    end
                end
                G_WAIT: begin
                    if (cell_empty) begin
                        cell_x <= next_x;
                        cell_y <= next_y;
                    end else begin
                        node_q    <= grid_dout;
                        out_x     <= coord_ext(cell_x);
                        out_y     <= coord_ext(cell_y);
                        out_err   <= 1'b0;
                        occ_count <= occ_count + DATA_W'(1);
                    end
                end
`ifdef CONSISTENCY_CHECK_EN
                P_WAIT: begin
                    if (pos_mismatch) begin
                        out_err   <= 1'b1;
                        err_count <= err_count + DATA_W'(1);
                    end
                end
`endif
                EMIT: begin
                    if (out_ready) begin
                        cell_x <= next_x;
                        cell_y <= next_y;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/placement_readout.md
# placement_readout

Post-placement scanner that reads back the grid and position RAMs filled by the placement engine and streams every occupied cell out as an (x, y, node) record over a valid/ready interface. It sits beside the placement engine on the read side of the same memories. With the consistency check compiled in, it also cross-checks each grid entry against the pos_X/pos_Y RAMs and flags mismatches. Typical uses are result dump, scoreboard feed or host readout.

## Interface
Parameters:
- N, 6, grid side; grid holds N*N cells, cell address = x*N+y
- DATA_W, 32, memory data width (signed; -1 = empty/unplaced)
- GRID_AW, 6, grid address width
- POS_AW, 7, pos_X/pos_Y address width

Ports:
- clk  in  1  clock; one clock; reset is asynchronous and active-low
- reset  in  1  asynchronous, active-low
- start  in  1  pulse; begins a scan when idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at scan end
- grid_re  out  1  grid read strobe
- grid_addr  out  GRID_AW  grid address
- grid_dout  in  DATA_W  grid read data
- px_re, py_re  out  1  pos_X / pos_Y read strobes
- px_addr, py_addr  out  POS_AW  node index
- px_dout, py_dout  in  DATA_W  position read data
- out_valid  out  1  record valid
- out_ready  in  1  sink accepts record
- out_x, out_y  out  DATA_W  cell coordinates
- out_node  out  DATA_W  node id stored in cell
- out_err  out  1  position mismatch for this record
- occ_count  out  DATA_W  occupied cells found in last/current scan
- err_count  out  DATA_W  mismatches found in last/current scan

## Operation
- Memory read latency is fixed: strobe and address driven in cycle t, data sampled at the end of cycle t+1.
- FSM states: IDLE, G_RD, G_WAIT, P_RD, P_WAIT, EMIT, DONE.
- IDLE:
  - On start, clear x, y, occ_count and err_count; set busy; go to G_RD.
  - start while busy is ignored.
- G_RD: grid_re=1, grid_addr=x*N+y; go to G_WAIT.
- G_WAIT: sample grid_dout as node.
  - If node == -1, advance the cell counter. Go to G_RD, or to DONE after cell (N-1, N-1).
  - Otherwise increment occ_count and go to P_RD. With the check compiled out, go to EMIT instead.
- P_RD: px_re=py_re=1 at address node[POS_AW-1:0]; go to P_WAIT.
- P_WAIT: out_err = (px_dout != x) || (py_dout != y); increment err_count if set; go to EMIT.
- EMIT:
  - out_valid=1, fields held stable.
  - On out_valid && out_ready, clear out_valid and advance the cell counter. Go to G_RD, or to DONE after the last cell.
- Cell counter: y increments first; when y wraps from N-1 to 0, x increments.
- DONE: done=1 for one cycle, busy=0; go to IDLE.
- occ_count and err_count hold their values until the next start.
- Reset at any time, including mid-scan, aborts immediately and puts the FSM in IDLE. All outputs go to 0: busy, done, out_valid, all strobes, all addresses, out_x/out_y/out_node/out_err, occ_count, err_count.
- No write strobes exist; the block never modifies memories.

## Timing
- Empty cell: 2 cycles (G_RD, G_WAIT).
- Occupied cell: 5 cycles with the check (G_RD, G_WAIT, P_RD, P_WAIT, EMIT) plus backpressure stall; 3 cycles without the check.
- Full empty grid: start at edge 0 → done pulse at cycle 2*N*N+1 (73 for N=6).
- out_valid stays asserted with stable data until accepted.
- No combinational path from out_ready to any output; out_valid is registered.
- Strobes are single-cycle pulses, never asserted in IDLE/EMIT/DONE.

## Configuration
- CONSISTENCY_CHECK_EN defined:
  - P_RD/P_WAIT are present.
  - px/py reads are issued.
  - out_err and err_count are live.
- Undefined:
  - States are skipped.
  - px_re/py_re are tied 0 and addresses are held 0.
  - out_err and err_count are constant 0.
  - Record order and content are otherwise identical.

## Test plan
- All 36 grid cells = -1, start → no out_valid, done at cycle 73, occ_count=0, err_count=0.
- grid[7]=3, pos_X[3]=1, pos_Y[3]=1, rest empty → exactly one record: x=1, y=1, node=3, out_err=0; occ_count=1.
- grid[7]=3, pos_X[3]=2 → record out_err=1, err_count=1 (with macro); out_err=0, err_count=0 (without).
- Cells 0 and 35 occupied, out_ready low 10 cycles on first record → record held stable, no second valid until acceptance, both records in address order.
- Reset asserted during P_WAIT → all outputs 0 asynchronously. After release, start rescans from cell 0 with counters cleared.
- start pulsed again while busy → ignored; single done pulse; occ_count unchanged by the extra pulse.
